alu_uart_ctrl: RTL

- Sequencer that drives the ALU datapath from a UART byte stream instead of buttons/switches.
- Collects operand A, operand B and the opcode as three consecutive received bytes, then presents them to the ALU.
- Captures the ALU result after one settle cycle and hands it to the UART transmitter, waiting for that byte to complete.
- Sits between uart_rx/uart_tx and the combinational ALU; it replaces the manual load path.

---
 rtl/alu_uart_ctrl_pkg.sv | 24 ++
 rtl/alu_uart_ctrl_timeout.sv | 41 ++++
 rtl/alu_uart_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_uart_ctrl_pkg.sv
// Shared definitions for the UART-driven ALU sequencer.
//   state_e : sequencer state encoding (3 bits)
//   Op*     : ALU opcode constants, shared with the ALU datapath
package alu_uart_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StGetB   = 3'd1,
      StGetOp  = 3'd2,
      StExec   = 3'd3,
      StSend   = 3'd4,
      StWaitTx = 3'd5
   } state_e;

   localparam logic [5:0] OpAdd = 6'h20;
   localparam logic [5:0] OpSub = 6'h22;
   localparam logic [5:0] OpAnd = 6'h24;
   localparam logic [5:0] OpOr  = 6'h25;
   localparam logic [5:0] OpXor = 6'h26;
   localparam logic [5:0] OpNor = 6'h27;
   localparam logic [5:0] OpSra = 6'h03;
   localparam logic [5:0] OpSrl = 6'h02;

endpackage

// File: rtl/alu_uart_ctrl_timeout.sv
// Frame timeout counter: counts idle cycles while enabled and flags the terminal cycle.
//   i_clock    : system clock
//   i_reset    : asynchronous active-low reset
//   i_clear    : synchronous clear (wins over counting)
//   i_enable   : count this cycle
//   o_terminal : high during the cycle in which the count equals TIMEOUT_CYCLES-1
module alu_uart_ctrl_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
   parameter int unsigned NB_TIMEOUT     = 26
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_terminal
);

   localparam logic [NB_TIMEOUT-1:0] CountMax = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

   logic [NB_TIMEOUT-1:0] count_q, count_d;

   assign o_terminal = i_enable && (count_q == CountMax);

   always_comb begin
      count_d = count_q;
      if (i_clear || o_terminal) begin
         count_d = '0;
      end else if (i_enable) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/alu_uart_ctrl.sv
// UART-driven ALU sequencer: receives A, B and opcode bytes, presents them to the
// combinational ALU, captures the result after one settle cycle and transmits it.
//   i_clock, i_reset         : clock, asynchronous active-low reset
//   i_rx_done, i_rx_data     : received byte strobe and data
//   i_tx_done                : transmitter finished current byte
//   i_alu_result             : ALU output for o_data_a/o_data_b/o_operation
//   o_data_a, o_data_b       : operands to the ALU
//   o_operation              : opcode to the ALU
//   o_tx_start, o_tx_data    : one-cycle transmit request and the byte to send
//   o_busy                   : frame in progress
//   o_timeout                : one-cycle pulse when a partial frame is abandoned
module alu_uart_ctrl
   import alu_uart_ctrl_pkg::*;
#(
   parameter int unsigned NB_DATA        = 8,
   parameter int unsigned NB_OP          = 6,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
   parameter int unsigned NB_TIMEOUT     = 26
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_rx_done,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_tx_done,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic [NB_DATA-1:0] o_data_a,
   output logic [NB_DATA-1:0] o_data_b,
   output logic [NB_OP-1:0]   o_operation,
   output logic               o_tx_start,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_busy,
   output logic               o_timeout
);

   state_e state_q, state_d;

   logic [NB_DATA-1:0] data_a_q, data_b_q, tx_data_q;
   logic [NB_OP-1:0]   operation_q;
   logic               tx_start_q, timeout_q;

   logic load_a, load_b, load_op, capture, abort;
   logic in_frame, terminal;

   assign in_frame = (state_q == StGetB) || (state_q == StGetOp);

   alu_uart_ctrl_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .NB_TIMEOUT     (NB_TIMEOUT)
   ) u_timeout (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_clear    (!in_frame || i_rx_done),
      .i_enable   (in_frame),
      .o_terminal (terminal)
   );

   // A byte arriving on the terminal cycle takes priority over the abort.
   always_comb begin
      state_d = state_q;
      load_a  = 1'b0;
      load_b  = 1'b0;
      load_op = 1'b0;
      capture = 1'b0;
      abort   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (i_rx_done) begin
               load_a  = 1'b1;
               state_d = StGetB;
            end
         end
         StGetB: begin
            if (i_rx_done) begin
               load_b  = 1'b1;
               state_d = StGetOp;
            end else if (terminal) begin
               abort   = 1'b1;
               state_d = StIdle;
            end
         end
         StGetOp: begin
            if (i_rx_done) begin
               load_op = 1'b1;
               state_d = StExec;
            end else if (terminal) begin
               abort   = 1'b1;
               state_d = StIdle;
            end
         end
         StExec: begin
            capture = 1'b1;
            state_d = StSend;
         end
         StSend:   state_d = StWaitTx;
         StWaitTx: if (i_tx_done) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q     <= StIdle;
         data_a_q    <= '0;
         data_b_q    <= '0;
         operation_q <= '0;
         tx_data_q   <= '0;
         tx_start_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         // Registered from the SEND state so the pulse lands two cycles after the opcode.
         tx_start_q <= (state_q == StSend);
         timeout_q  <= abort;
         if (load_a)  data_a_q    <= i_rx_data;
         if (load_b)  data_b_q    <= i_rx_data;
         if (load_op) operation_q <= i_rx_data[NB_OP-1:0];
         if (capture) tx_data_q   <= i_alu_result;
      end
   end

   assign o_data_a    = data_a_q;
   assign o_data_b    = data_b_q;
   assign o_operation = operation_q;
   assign o_tx_data   = tx_data_q;
   assign o_tx_start  = tx_start_q;
   assign o_timeout   = timeout_q;
   assign o_busy      = (state_q != StIdle);

endmodule
